calc1_port_driver: RTL
======================

// Module: calc1_port_driver
// PURPOSE
//  Request/response sequencer for one calc1 port. Takes a whole operation (cmd + two operands)
//  on a valid/ready interface, serialises it onto the calc1 two-cycle cmd/data protocol, waits
//  for the port's out_resp, and returns resp+data on a valid/ready result interface.
//  Four instances sit directly upstream/downstream of calc1, one per port (req1..req4).
// PARAMETERS
//  TIMEOUT_CYCLES  64  WAIT cycles before a timeout result is forced (used only with the macro)
//  CNT_W           7   width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES
// PORTS
//  c_clk         in   1   single clock, rising edge
//  reset         in   1   asynchronous, active-high reset
//  op_valid      in   1   operation offered
//  op_ready      out  1   driver can accept an operation
//  op_cmd        in   [0:3]  calc1 command (1 add, 2 sub, 5 shl, 6 shr; others passed through)
//  op_data1      in   [0:31] operand 1
//  op_data2      in   [0:31] operand 2
//  req_cmd_out   out  [0:3]  to calc1 reqN_cmd_in
//  req_data_out  out  [0:31] to calc1 reqN_data_in
//  out_resp_in   in   [0:1]  from calc1 out_respN
//  out_data_in   in   [0:31] from calc1 out_dataN
//  res_valid     out  1   result available
//  res_ready     in   1   consumer takes result
//  res_resp      out  [0:1]  1 ok, 2 overflow/underflow/invalid cmd, 3 timeout (macro only)
//  res_data      out  [0:31] captured calc1 result
//  busy          out  1   high in every state except IDLE
//  stray_resp    out  1   sticky: nonzero out_resp_in seen while not expecting one
// BEHAVIOUR
//  - Reset: state IDLE; req_cmd_out=0, req_data_out=0, res_valid=0, res_resp=0, res_data=0,
//    busy=0, stray_resp=0, counter=0. Reset mid-operation abandons it; no result emitted.
//  - FSM IDLE -> CMD -> OPND2 -> WAIT -> HOLD -> IDLE.
//  - IDLE: op_ready=1. Accept on op_valid&op_ready at clock edge; latch cmd/data1/data2.
//    op_cmd==0 is accepted and dropped: stay IDLE, no bus activity, no result.
//  - CMD (1 cycle): req_cmd_out=latched cmd, req_data_out=data1.
//  - OPND2 (1 cycle): req_cmd_out=0, req_data_out=data2.
//  - WAIT: req_cmd_out=0, req_data_out=0; stays until out_resp_in!=0.
//  - Capture: in OPND2 or WAIT, out_resp_in!=0 -> res_resp/res_data registered, go HOLD.
//  - HOLD: res_valid=1, res_resp/res_data stable until res_ready; res_valid&res_ready -> IDLE
//    next cycle with res_valid=0. op_ready=0 throughout; no new op until result consumed.
//  - Minimum op-accept to res_valid: 3 cycles (response in the OPND2 cycle).
//  - out_resp_in!=0 in IDLE, CMD or HOLD: ignored for data; sets stray_resp (cleared by reset).
//  - Simultaneous res_ready and op_valid in HOLD: result retires; op accepted no earlier than
//    the following IDLE cycle.
//  - Result data is never modified; widths pass straight through, no arithmetic in this block.
// CONFIGURATION
//  CALC1_DRV_TIMEOUT_EN defined: counter clears on entry to WAIT, increments each WAIT cycle;
//    on reaching TIMEOUT_CYCLES with no response -> res_resp=3, res_data=0, go HOLD. A late
//    response after timeout sets stray_resp.
//  Not defined: no counter logic; WAIT lasts until a response arrives; res_resp never 3.
// TESTING
//  1 add: cmd1 d1=0x0000_0001 d2=0x01FF_FFFF -> bus 1/0x1 then 0/0x01FF_FFFF; res 1/0x0200_0000.
//  2 overflow: cmd1 0xFFFF_FFFF + 0x1 -> res_resp=2, res_data=0; stray_resp stays 0.
//  3 underflow: cmd2 0x1 - 0xF -> res_resp=2; shl cmd5 0x1 by 1 -> res_resp=1, res_data=0x2.
//  4 backpressure: res_ready low 5 cycles after res_valid -> res_valid, resp, data stable;
//    op_ready=0; retire on res_ready -> op_ready=1 next cycle.
//  5 op_cmd=0 with random data -> req_cmd_out stays 0, no res_valid, op_ready stays 1;
//    force out_resp_in=1 in IDLE -> stray_resp=1.
//  6 timeout (macro, TIMEOUT_CYCLES=8, model silent) -> res_resp=3, res_data=0 after 8 WAIT
//    cycles; without macro busy stays 1; reset mid-WAIT -> IDLE, all outputs 0.

Source files
------------

// File: rtl/calc1_port_driver.sv
// calc1_port_driver: serialises one operation onto a calc1 port and returns its result.
// Optional WAIT timeout enabled by defining CALC1_DRV_TIMEOUT_EN.
module calc1_port_driver #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [0:3]  op_cmd,
    input  logic [0:31] op_data1,
    input  logic [0:31] op_data2,
    output logic [0:3]  req_cmd_out,
    output logic [0:31] req_data_out,
    input  logic [0:1]  out_resp_in,
    input  logic [0:31] out_data_in,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [0:1]  res_resp,
    output logic [0:31] res_data,
    output logic        busy,
    output logic        stray_resp
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CMD   = 3'd1;
    localparam logic [2:0] S_OPND2 = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    if (2 ** CNT_W <= TIMEOUT_CYCLES) begin : g_bad_cnt_w
        $error("CNT_W too narrow for TIMEOUT_CYCLES");
    end

    logic [2:0]  state_q, state_d;
    logic [0:3]  cmd_q, cmd_d;
    logic [0:31] d1_q, d1_d;
    logic [0:31] d2_q, d2_d;
    logic [0:1]  resp_q, resp_d;
    logic [0:31] rdata_q, rdata_d;
    logic        stray_q, stray_d;
    logic        resp_seen;

`ifdef CALC1_DRV_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    assign resp_seen = (out_resp_in != 2'd0);

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        resp_d  = resp_q;
        rdata_d = rdata_q;
        stray_d = stray_q;
`ifdef CALC1_DRV_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                stray_d = stray_q | resp_seen;
                // A zero command is consumed without touching the bus
                if (op_valid && op_cmd != 4'd0) begin
                    cmd_d   = op_cmd;
                    d1_d    = op_data1;
                    d2_d    = op_data2;
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                stray_d = stray_q | resp_seen;
                state_d = S_OPND2;
            end
            S_OPND2: begin
`ifdef CALC1_DRV_TIMEOUT_EN
                cnt_d = '0;
`endif
                if (resp_seen) begin
                    resp_d  = out_resp_in;
                    rdata_d = out_data_in;
                    state_d = S_HOLD;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (resp_seen) begin
                    resp_d  = out_resp_in;
                    rdata_d = out_data_in;
                    state_d = S_HOLD;
`ifdef CALC1_DRV_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    resp_d  = 2'd3;
                    rdata_d = '0;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            S_HOLD: begin
                stray_d = stray_q | resp_seen;
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            resp_q  <= '0;
            rdata_q <= '0;
            stray_q <= 1'b0;
`ifdef CALC1_DRV_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
            stray_q <= stray_d;
`ifdef CALC1_DRV_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        req_cmd_out  = '0;
        req_data_out = '0;
        if (state_q == S_CMD) begin
            req_cmd_out  = cmd_q;
            req_data_out = d1_q;
        end else if (state_q == S_OPND2) begin
            req_data_out = d2_q;
        end
    end

    assign op_ready   = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign res_valid  = (state_q == S_HOLD);
    assign res_resp   = resp_q;
    assign res_data   = rdata_q;
    assign stray_resp = stray_q;

endmodule
